// File: rtl/addsub.sv
// Multi-cycle IEEE-754 single-precision adder.
// Recomputes whenever the operands change, then holds the result.
module addsub (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] add_result,
  output logic        add_done,
  output logic        add_overflow
);

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, DONE
  } state_t;

  state_t      state;
  logic [31:0] a_q, b_q;

  logic        big_sign, eff_sub;
  logic [7:0]  big_exp;
  logic [26:0] big_m, small_m;
  logic        spec_q;
  logic [31:0] spec_val;

  logic [27:0] sum_q;
  logic [7:0]  sum_exp;
  logic        sum_sign;

  function automatic logic [4:0] lzc(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic [30:0] mag_a, mag_b;
  logic        swap;
  logic [31:0] hi, lo;
  logic [23:0] hi_man, lo_man;
  logic [7:0]  diff;
  logic [49:0] wide;
  logic [26:0] lo_al;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [31:0] sp_v;

  // Order operands by magnitude and align the smaller one with GRS bits.
  always_comb begin
    mag_a  = (a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
    mag_b  = (b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
    swap   = mag_b > mag_a;
    hi     = swap ? b_q : a_q;
    lo     = swap ? a_q : b_q;
    hi_man = (hi[30:23] == 8'd0) ? 24'd0 : {1'b1, hi[22:0]};
    lo_man = (lo[30:23] == 8'd0) ? 24'd0 : {1'b1, lo[22:0]};
    diff   = hi[30:23] - lo[30:23];
    wide   = {lo_man, 26'd0} >> diff;
    if (diff > 8'd26)
      lo_al = {26'd0, |lo_man};
    else
      lo_al = {wide[49:24], |wide[23:0]};
    a_nan = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31])))
      sp_v = 32'h7FC00000;
    else if (a_inf)
      sp_v = a_q;
    else
      sp_v = b_q;
  end

  logic [27:0] sum_c;

  // Magnitude add or subtract; the larger operand is always first.
  always_comb begin
    if (eff_sub)
      sum_c = {1'b0, big_m} - {1'b0, small_m};
    else
      sum_c = {1'b0, big_m} + {1'b0, small_m};
  end

  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne, re;
  logic              rnd;
  logic [24:0]       mant25;
  logic [22:0]       frac;
  logic [31:0]       res_c;
  logic              ovf_c;

  // Normalize, round to nearest even, and resolve special cases.
  always_comb begin
    lz = lzc(sum_q[26:0]);
    if (sum_q[27]) begin
      nm = {sum_q[27:2], sum_q[1] | sum_q[0]};
      ne = $signed({2'b00, sum_exp}) + 10'sd1;
    end else begin
      nm = sum_q[26:0] << lz;
      ne = $signed({2'b00, sum_exp}) - $signed({5'd0, lz});
    end
    rnd    = nm[2] & (nm[1] | nm[0] | nm[3]);
    mant25 = {1'b0, nm[26:3]} + 25'(rnd);
    re     = mant25[24] ? ne + 10'sd1 : ne;
    frac   = mant25[24] ? mant25[23:1] : mant25[22:0];
    ovf_c  = 1'b0;
    if (spec_q)
      res_c = spec_val;
    else if (sum_q == 28'd0)
      res_c = 32'd0;
    else if (re >= 10'sd255) begin
      res_c = {sum_sign, 8'hFF, 23'd0};
      ovf_c = 1'b1;
    end else if (re < 10'sd1)
      res_c = 32'd0;
    else
      res_c = {sum_sign, re[7:0], frac};
  end

  // Control sequencing and all pipeline registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state        <= IDLE;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      add_result   <= 32'd0;
      add_done     <= 1'b0;
      add_overflow <= 1'b0;
      big_sign     <= 1'b0;
      eff_sub      <= 1'b0;
      big_exp      <= 8'd0;
      big_m        <= 27'd0;
      small_m      <= 27'd0;
      spec_q       <= 1'b0;
      spec_val     <= 32'd0;
      sum_q        <= 28'd0;
      sum_exp      <= 8'd0;
      sum_sign     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          a_q      <= op1;
          b_q      <= op2;
          add_done <= 1'b0;
          state    <= ALIGN;
        end
        ALIGN: begin
          big_sign <= hi[31];
          eff_sub  <= hi[31] ^ lo[31];
          big_exp  <= hi[30:23];
          big_m    <= {hi_man, 3'b000};
          small_m  <= lo_al;
          spec_q   <= a_nan | b_nan | a_inf | b_inf;
          spec_val <= sp_v;
          state    <= ADD;
        end
        ADD: begin
          sum_q    <= sum_c;
          sum_exp  <= big_exp;
          sum_sign <= big_sign;
          state    <= NORM;
        end
        NORM: begin
          add_result   <= res_c;
          add_overflow <= ovf_c;
          add_done     <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if ((op1 != a_q) || (op2 != b_q)) begin
            a_q      <= op1;
            b_q      <= op2;
            add_done <= 1'b0;
            state    <= ALIGN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub.sv
// Directed scoreboard bench for the multi-cycle float adder.
// Expected results are queued at drive time and popped on add_done.
module tb_addsub;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] op1, op2;
  logic [31:0] add_result;
  logic        add_done;
  logic        add_overflow;

  addsub dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .op1          (op1),
    .op2          (op2),
    .add_result   (add_result),
    .add_done     (add_done),
    .add_overflow (add_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o,
                       input string tag);
    exp_t e;
    op1   = a;
    op2   = b;
    e.res = r;
    e.ovf = o;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic wait_done(output int cyc);
    bit seen0;
    seen0 = 0;
    cyc   = 0;
    while (cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!add_done) seen0 = 1;
      if (seen0 && add_done) break;
    end
  endtask

  task automatic pop_check(input int cyc, input int want);
    exp_t e;
    e = q.pop_front();
    check({e.tag, "_done"}, {31'd0, add_done}, 32'd1);
    check({e.tag, "_lat"}, cyc, want);
    check({e.tag, "_res"}, add_result, e.res);
    check({e.tag, "_ovf"}, {31'd0, add_overflow}, {31'd0, e.ovf});
  endtask

  localparam int N = 17;
  logic [31:0] ta [N] = '{
    32'h40200000, 32'h41480000, 32'hC61C4238, 32'hC61C4238,
    32'hC0840000, 32'hC475C000, 32'h4A1FE982, 32'h7F7FFFFF,
    32'h3F800000, 32'h7F800001, 32'h7F800000, 32'hFF800000,
    32'h3F800000, 32'h3F800000, 32'h3FFFFFFF, 32'h00800000,
    32'h00000001};
  logic [31:0] tb_ [N] = '{
    32'h40600000, 32'h418C0000, 32'hC61C4238, 32'h461C4238,
    32'h40800000, 32'h4A1FE982, 32'hC475C000, 32'h7F7FFFFF,
    32'h40000000, 32'h3F800000, 32'hFF800000, 32'h3F800000,
    32'h33800000, 32'h33C00000, 32'h33C00000, 32'h80800001,
    32'h3F800000};
  logic [31:0] tr [N] = '{
    32'h40C00000, 32'h41F00000, 32'hC69C4238, 32'h00000000,
    32'hBE000000, 32'h4A1FDA26, 32'h4A1FDA26, 32'h7F800000,
    32'h40400000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
    32'h3F800000, 32'h3F800001, 32'h40000000, 32'h00000000,
    32'h3F800000};
  logic to [N] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int cyc;
    op1   = 32'd0;
    op2   = 32'd0;
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_res", add_result, 32'd0);
    check("rst_done", {31'd0, add_done}, 32'd0);
    check("rst_ovf", {31'd0, add_overflow}, 32'd0);

    @(negedge clk);
    n_rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      drive(ta[i], tb_[i], tr[i], to[i], $sformatf("vec%0d", i));
      wait_done(cyc);
      pop_check(cyc, 4);
    end

    @(negedge clk);
    drive(32'h40A00000, 32'h40A00000, 32'h41200000, 1'b0, "midQ");
    @(posedge clk);
    @(negedge clk);
    drive(32'h3F800000, 32'hBF000000, 32'h3F000000, 1'b0, "midR");
    wait_done(cyc);
    pop_check(cyc, 3);
    wait_done(cyc);
    pop_check(cyc, 4);

    @(negedge clk);
    op1 = 32'h42C80000;
    op2 = 32'h3F800000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_res", add_result, 32'd0);
    check("abort_done", {31'd0, add_done}, 32'd0);
    check("abort_ovf", {31'd0, add_overflow}, 32'd0);

    @(negedge clk);
    n_rst = 1'b0;
    drive(32'h40400000, 32'hC0000000, 32'h3F800000, 1'b0, "post_rst");
    wait_done(cyc);
    pop_check(cyc, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub.md
ADDSUB -- requirements
Module: addsub

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 n_rst  input  1  Reset, synchronous and active-high: asserted when 1, sampled on rising clk.
REQ-003 op1  input  32  IEEE-754 single-precision operand A (sign[31], exp[30:23], frac[22:0]).
REQ-004 op2  input  32  IEEE-754 single-precision operand B, same format.
REQ-005 add_result  output  32  Registered single-precision sum op1+op2.
REQ-006 add_done  output  1  Registered; 1 when add_result matches the currently captured operand pair.
REQ-007 add_overflow  output  1  Registered; 1 when the finite-operand sum overflowed to infinity.

Function
REQ-008 Operation: add_result SHALL be the signed sum of op1 and op2; subtraction is done by the caller flipping the sign bit.
REQ-009 FSM states: IDLE, ALIGN, ADD, NORM, DONE.
  - IDLE: capture op1/op2 into internal registers; next ALIGN.
  - ALIGN: compare exponents, swap so the larger magnitude is first, right-shift the smaller mantissa (hidden bit restored) by the exponent difference, collecting guard/round/sticky bits; next ADD.
  - ADD: add mantissas on equal signs, else subtract smaller from larger; sign = sign of larger magnitude; next NORM.
  - NORM: normalize (1-bit right shift on carry-out, left shift by leading-zero count otherwise), round, register add_result/add_overflow; next DONE.
  - DONE: hold all outputs; if op1 or op2 differs from the captured pair, capture the new pair, clear add_done, go to ALIGN; else stay.
REQ-010 Latency: operands captured at edge k give add_result and add_done=1 after edge k+3.
REQ-011 add_done SHALL be 0 in IDLE, ALIGN, ADD and NORM, and 1 in DONE.
REQ-012 Operand changes during ALIGN/ADD/NORM SHALL be ignored until DONE, which then restarts on the new values.
REQ-013 Rounding: round-to-nearest-even using guard, round and sticky bits; a rounding carry renormalizes and increments the exponent.
REQ-014 Exact cancellation or zero sum SHALL yield +0 (32'h00000000).
REQ-015 Inputs with exponent 0 (zero/denormal) SHALL be treated as zero; a result exponent below 1 SHALL flush to +0 with add_overflow=0.
REQ-016 If the rounded exponent of a finite sum reaches 255, the block SHALL output signed infinity with add_overflow=1; otherwise add_overflow=0.
REQ-017 Special inputs:
  - any NaN, or +inf plus -inf: 32'h7FC00000;
  - otherwise, an infinite operand propagates as that infinity;
  - add_overflow=0 in all these cases.
REQ-018 The internal datapath SHALL be at least 27 bits (hidden bit + 23 fraction + guard/round/sticky) plus 1 carry bit.

Reset
REQ-019 When n_rst=1 at a rising edge: state is IDLE, add_result=0, add_done=0, add_overflow=0, captured operands=0.
REQ-020 Reset asserted in any state, including mid-operation, SHALL abort the computation and apply REQ-019 on that edge.
REQ-021 After n_rst returns to 0, the first edge captures the operands (IDLE), so the result is valid 3 edges later.

Verification
REQ-022 Hold reset for 5 cycles -> add_result=0, add_done=0, add_overflow=0.
REQ-023 0x40200000 + 0x40600000 (2.5+3.5) -> 0x40C00000, add_done=1 within 4 cycles; 0x41480000 + 0x418C0000 -> 0x41F00000.
REQ-024 0xC61C4238 + 0xC61C4238 -> 0xC69C4238; 0xC61C4238 + 0x461C4238 -> 0x00000000.
REQ-025 Mixed signs and exponents:
  - 0xC0840000 + 0x40800000 (-4.125+4.0) -> 0xBE000000;
  - 0xC475C000 + 0x4A1FE982 -> 0x4A1FDA26;
  - operand order swapped -> identical result.
REQ-026 Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with add_overflow=1; the next normal pair clears add_overflow.
REQ-027 Change operands during ALIGN -> the old result completes first (add_done pulses to 1), then the new result follows within 4 further cycles; assert reset during ADD -> outputs return to 0 on that edge.
